// File: rtl/ibex_taint_arb_pkg.sv
// Shared types and default configuration for the taint-tracking instr/data SRAM arbiter.
package ibex_taint_arb_pkg;

  localparam int unsigned DefAddrWidth = 15;
  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefMaxWait   = 4;
  localparam int unsigned DefCntWidth  = 16;

  typedef enum logic {
    OwnerInstr = 1'b0,
    OwnerData  = 1'b1
  } owner_e;

  typedef struct packed {
    logic [DefAddrWidth-1:0] addr;
    logic [DefDataWidth-1:0] wdata;
    logic [DefDataWidth-1:0] strb;
    logic                    we;
  } req_t;

  typedef struct packed {
    logic [DefAddrWidth-1:0] addr;
    logic [DefDataWidth-1:0] wdata;
    logic [DefDataWidth-1:0] strb;
    logic                    we;
  } req_t0_t;

endpackage

// File: rtl/ibex_taint_arb_starve_ctr.sv
// Counts consecutive denied instruction cycles; raises instr_prio_o once the limit is reached.
module ibex_taint_arb_starve_ctr #(
  parameter int unsigned MaxWait = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic instr_req_i,
  input  logic instr_gnt_i,
  output logic instr_prio_o
);

  localparam int unsigned WaitWidth = $clog2(MaxWait + 1);

  logic [WaitWidth-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!instr_req_i || instr_gnt_i) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WaitWidth'(MaxWait)) begin
      wait_cnt_d = wait_cnt_q + WaitWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign instr_prio_o = (wait_cnt_q == WaitWidth'(MaxWait));

endmodule

// File: rtl/ibex_taint_mem_arbiter.sv
// Shares one 1-cycle SRAM (plus shadow taint SRAM) between Ibex instr and data ports,
// data-priority with anti-starvation; counts grants issued with a tainted address.
module ibex_taint_mem_arbiter
  import ibex_taint_arb_pkg::*;
#(
  parameter int unsigned AddrWidth = DefAddrWidth,
  parameter int unsigned DataWidth = DefDataWidth,
  parameter int unsigned MaxWait   = DefMaxWait,
  parameter int unsigned CntWidth  = DefCntWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 instr_req_i,
  output logic                 instr_gnt_o,
  input  logic [AddrWidth-1:0] instr_addr_i,
  input  logic [DataWidth-1:0] instr_wdata_i,
  input  logic [DataWidth-1:0] instr_strb_i,
  input  logic                 instr_we_i,
  input  logic                 instr_req_i_t0,
  input  logic [AddrWidth-1:0] instr_addr_i_t0,
  input  logic [DataWidth-1:0] instr_wdata_i_t0,
  input  logic [DataWidth-1:0] instr_strb_i_t0,
  input  logic                 instr_we_i_t0,
  output logic                 instr_rvalid_o,
  output logic [DataWidth-1:0] instr_rdata_o,
  output logic [DataWidth-1:0] instr_rdata_o_t0,
  input  logic                 data_req_i,
  output logic                 data_gnt_o,
  input  logic [AddrWidth-1:0] data_addr_i,
  input  logic [DataWidth-1:0] data_wdata_i,
  input  logic [DataWidth-1:0] data_strb_i,
  input  logic                 data_we_i,
  input  logic                 data_req_i_t0,
  input  logic [AddrWidth-1:0] data_addr_i_t0,
  input  logic [DataWidth-1:0] data_wdata_i_t0,
  input  logic [DataWidth-1:0] data_strb_i_t0,
  input  logic                 data_we_i_t0,
  output logic                 data_rvalid_o,
  output logic [DataWidth-1:0] data_rdata_o,
  output logic [DataWidth-1:0] data_rdata_o_t0,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  output logic [DataWidth-1:0] mem_strb_o,
  output logic                 mem_req_o_t0,
  output logic                 mem_we_o_t0,
  output logic [AddrWidth-1:0] mem_addr_o_t0,
  output logic [DataWidth-1:0] mem_wdata_o_t0,
  output logic [DataWidth-1:0] mem_strb_o_t0,
  input  logic [DataWidth-1:0] mem_rdata_i,
  input  logic [DataWidth-1:0] mem_rdata_i_t0,
  output logic [CntWidth-1:0]  tainted_acc_cnt_o
);

  logic          instr_prio;
  logic          instr_win, data_win, any_win;
  logic          resp_valid_q;
  owner_e        resp_owner_q;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  ibex_taint_arb_starve_ctr #(
    .MaxWait(MaxWait)
  ) u_starve_ctr (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .instr_req_i (instr_req_i),
    .instr_gnt_i (instr_win),
    .instr_prio_o(instr_prio)
  );

  // Arbitration on untainted request bits only; winner's payload and taint go to the SRAM.
  always_comb begin
    data_win       = data_req_i && !(instr_req_i && instr_prio);
    instr_win      = instr_req_i && !data_win;
    any_win        = instr_win || data_win;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    mem_strb_o     = '0;
    mem_req_o_t0   = 1'b0;
    mem_we_o_t0    = 1'b0;
    mem_addr_o_t0  = '0;
    mem_wdata_o_t0 = '0;
    mem_strb_o_t0  = '0;
    if (instr_win) begin
      mem_req_o      = 1'b1;
      mem_we_o       = instr_we_i;
      mem_addr_o     = instr_addr_i;
      mem_wdata_o    = instr_wdata_i;
      mem_strb_o     = instr_strb_i;
      mem_req_o_t0   = instr_req_i_t0;
      mem_we_o_t0    = instr_we_i_t0;
      mem_addr_o_t0  = instr_addr_i_t0;
      mem_wdata_o_t0 = instr_wdata_i_t0;
      mem_strb_o_t0  = instr_strb_i_t0;
    end else if (data_win) begin
      mem_req_o      = 1'b1;
      mem_we_o       = data_we_i;
      mem_addr_o     = data_addr_i;
      mem_wdata_o    = data_wdata_i;
      mem_strb_o     = data_strb_i;
      mem_req_o_t0   = data_req_i_t0;
      mem_we_o_t0    = data_we_i_t0;
      mem_addr_o_t0  = data_addr_i_t0;
      mem_wdata_o_t0 = data_wdata_i_t0;
      mem_strb_o_t0  = data_strb_i_t0;
    end
  end

  assign instr_gnt_o = instr_win;
  assign data_gnt_o  = data_win;

  always_comb begin
    cnt_d = cnt_q;
    if (any_win && (|mem_addr_o_t0) && (cnt_q != {CntWidth{1'b1}})) begin
      cnt_d = cnt_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_valid_q <= 1'b0;
      resp_owner_q <= OwnerInstr;
      cnt_q        <= '0;
    end else begin
      resp_valid_q <= any_win;
      resp_owner_q <= instr_win ? OwnerInstr : OwnerData;
      cnt_q        <= cnt_d;
    end
  end

  // Non-owner response data is forced to zero so no taint leaks across ports.
  always_comb begin
    instr_rvalid_o   = resp_valid_q && (resp_owner_q == OwnerInstr);
    data_rvalid_o    = resp_valid_q && (resp_owner_q == OwnerData);
    instr_rdata_o    = instr_rvalid_o ? mem_rdata_i    : '0;
    instr_rdata_o_t0 = instr_rvalid_o ? mem_rdata_i_t0 : '0;
    data_rdata_o     = data_rvalid_o  ? mem_rdata_i    : '0;
    data_rdata_o_t0  = data_rvalid_o  ? mem_rdata_i_t0 : '0;
  end

  assign tainted_acc_cnt_o = cnt_q;

endmodule
